// File: rtl/stream_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : stream_fifo_pkg
// Purpose : Shared helpers for the stream FIFO: ceil-log2 and the pointer /
//           occupancy width derivations from a FIFO depth.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package stream_fifo_pkg;

  // Ceiling log2; clog2(1) == 0.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

  // Pointer width: wraps modulo depth.
  function automatic int addr_w(input int depth);
    return clog2(depth);
  endfunction

  // Occupancy width: one extra bit so that "full" (== depth) is representable.
  function automatic int cnt_w(input int depth);
    return clog2(depth) + 1;
  endfunction

  localparam int DEFAULT_DEPTH  = 4096;
  localparam int DEFAULT_ADDR_W = addr_w(DEFAULT_DEPTH);
  localparam int DEFAULT_CNT_W  = cnt_w(DEFAULT_DEPTH);

endpackage
`default_nettype wire

// File: rtl/stream_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module  : stream_fifo_ram
// Purpose : Simple dual-port RAM, WIDTH x DEPTH, synchronous write and
//           registered read (read register holds when rd_en is low).
// Ports   : clk              - clock
//           wr_en/wr_addr/wr_data - write port
//           rd_en/rd_addr    - read request
//           rd_data          - registered read data
// Revision: 1.0 - initial release
// ============================================================================
module stream_fifo_ram #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/stream_fifo_axis.sv
`default_nettype none
// ============================================================================
// Module  : stream_fifo_axis
// Purpose : Single-clock FIFO buffering a valid-only sample stream and
//           replaying it first-word-fall-through as an AXI4-Stream master,
//           with tlast every PKT_LEN beats and a sticky overflow flag.
// Ports   : m00_axis_aclk    - clock
//           m00_axis_aresetn - asynchronous active-low reset
//           din_valid/din    - input samples (no backpressure)
//           m00_axis_t*      - AXI4-Stream master
//           overflow         - sticky, a sample was dropped while full
// Revision: 1.0 - initial release
// ============================================================================
module stream_fifo_axis
  import stream_fifo_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4096,
  parameter int PKT_LEN = 1024
) (
  input  logic               m00_axis_aclk,
  input  logic               m00_axis_aresetn,
  input  logic               din_valid,
  input  logic [WIDTH-1:0]   din,
  input  logic               m00_axis_tready,
  output logic               m00_axis_tvalid,
  output logic [WIDTH-1:0]   m00_axis_tdata,
  output logic [WIDTH/8-1:0] m00_axis_tstrb,
  output logic               m00_axis_tlast,
  output logic               overflow
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam int CNT_W  = cnt_w(DEPTH);
  localparam int BEAT_W = (clog2(PKT_LEN) < 1) ? 1 : clog2(PKT_LEN);

  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

  logic              clk;
  logic              rst_n;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CNT_W-1:0]  occupancy;
  logic              ram_vld;      // RAM read register holds an unconsumed word
  logic              tvalid_r;
  logic [WIDTH-1:0]  tdata_r;
  logic [BEAT_W-1:0] beat_cnt;
  logic              overflow_r;

  logic              wr_en;
  logic              out_fire;
  logic              out_load;
  logic              ram_rd;
  logic [CNT_W-1:0]  ram_words;
  logic [WIDTH-1:0]  ram_dout;

  assign clk   = m00_axis_aclk;
  assign rst_n = m00_axis_aresetn;

  // Fullness uses the registered occupancy, so a beat leaving in the same
  // cycle does not make room for this cycle's write.
  assign wr_en    = din_valid && (occupancy != FULL_CNT);
  assign out_fire = tvalid_r && m00_axis_tready;

  // Output register refills from the RAM read register whenever it is empty
  // or its current beat is being accepted.
  assign out_load = ram_vld && (!tvalid_r || out_fire);

  // Words still sitting in the array (occupancy minus the two pipeline stages).
  assign ram_words = occupancy
                   - {{(CNT_W-1){1'b0}}, ram_vld}
                   - {{(CNT_W-1){1'b0}}, tvalid_r};

  // Issue a read when the read register is free or being drained this cycle.
  assign ram_rd = (ram_words != '0) && (!ram_vld || out_load);

  stream_fifo_ram #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (din),
    .rd_en   (ram_rd),
    .rd_addr (rd_ptr),
    .rd_data (ram_dout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occupancy  <= '0;
      ram_vld    <= 1'b0;
      tvalid_r   <= 1'b0;
      tdata_r    <= '0;
      beat_cnt   <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (ram_rd) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      if (din_valid && !wr_en) begin
        overflow_r <= 1'b1;
      end

      case ({wr_en, out_fire})
        2'b10:   occupancy <= occupancy + CNT_W'(1);
        2'b01:   occupancy <= occupancy - CNT_W'(1);
        default: occupancy <= occupancy;
      endcase

      if (ram_rd) begin
        ram_vld <= 1'b1;
      end else if (out_load) begin
        ram_vld <= 1'b0;
      end

      // tdata keeps its last value when the FIFO runs empty.
      if (out_load) begin
        tvalid_r <= 1'b1;
        tdata_r  <= ram_dout;
      end else if (out_fire) begin
        tvalid_r <= 1'b0;
      end

      // Packet position advances only on accepted beats; idle gaps do not
      // close a packet.
      if (out_fire) begin
        beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + BEAT_W'(1);
      end
    end
  end

  assign m00_axis_tvalid = tvalid_r;
  assign m00_axis_tdata  = tdata_r;
  assign m00_axis_tstrb  = '1;
  assign m00_axis_tlast  = tvalid_r && (beat_cnt == LAST_BEAT);
  assign overflow        = overflow_r;

endmodule
`default_nettype wire

// File: tb/tb_stream_fifo_axis.sv
`default_nettype none
// ============================================================================
// Module  : tb_stream_fifo_axis
// Purpose : Scoreboard bench for stream_fifo_axis (WIDTH=32, DEPTH=4096,
//           PKT_LEN=1024): reset, fill/drain, latency, overflow, concurrent
//           and backpressure scenarios.
// Revision: 1.0 - initial release
// ============================================================================
module tb_stream_fifo_axis;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din_valid = 1'b0;
  logic [31:0] din = '0;
  logic        tready = 1'b0;
  logic        tvalid;
  logic [31:0] tdata;
  logic [3:0]  tstrb;
  logic        tlast;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  logic [32:0] sb[$];   // {last, data}
  int          push_idx = 0;

  always #5 clk = ~clk;

  stream_fifo_axis #(
    .WIDTH   (32),
    .DEPTH   (4096),
    .PKT_LEN (1024)
  ) dut (
    .m00_axis_aclk    (clk),
    .m00_axis_aresetn (rst_n),
    .din_valid        (din_valid),
    .din              (din),
    .m00_axis_tready  (tready),
    .m00_axis_tvalid  (tvalid),
    .m00_axis_tdata   (tdata),
    .m00_axis_tstrb   (tstrb),
    .m00_axis_tlast   (tlast),
    .overflow         (overflow)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Expected beat: tlast on every 1024th accepted word since reset.
  task automatic push(input logic [31:0] d);
    logic last;
    last = ((push_idx % 1024) == 1023);
    sb.push_back({last, d});
    push_idx++;
  endtask

  task automatic write_word(input logic [31:0] d, input bit accept);
    @(negedge clk);
    din_valid = 1'b1;
    din       = d;
    if (accept) push(d);
  endtask

  task automatic end_writes();
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    din_valid = 1'b0;
    tready    = 1'b0;
    sb.delete();
    push_idx  = 0;
    repeat (10) @(negedge clk);
    #1;
    check("rst_tvalid",   {63'd0, tvalid},   64'd0);
    check("rst_tlast",    {63'd0, tlast},    64'd0);
    check("rst_overflow", {63'd0, overflow}, 64'd0);
    check("rst_tstrb",    {60'd0, tstrb},    64'hF);
    check("rst_tdata",    {32'd0, tdata},    64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_empty(input string name, input int limit);
    int c;
    c = 0;
    while (sb.size() > 0 && c < limit) begin
      @(negedge clk);
      c++;
    end
    #2;
    check({name, "_drained"}, 64'(sb.size()), 64'd0);
  endtask

  // Monitor: pops the scoreboard on every accepted beat and checks that a
  // stalled beat is held unchanged.
  initial begin
    bit          prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;
    logic [32:0] exp;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_tvalid", {63'd0, tvalid}, 64'd1);
          check("stall_tdata",  {32'd0, tdata},  {32'd0, prev_data});
          check("stall_tlast",  {63'd0, tlast},  {63'd0, prev_last});
        end
        if (tvalid && tready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got data %h, expected no beat", tdata);
          end else begin
            exp = sb.pop_front();
            check("beat_tdata", {32'd0, tdata}, {32'd0, exp[31:0]});
            check("beat_tlast", {63'd0, tlast}, {63'd0, exp[32]});
          end
        end
        prev_stall = tvalid && !tready;
        prev_data  = tdata;
        prev_last  = tlast;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;

    // Reset
    do_reset();

    // Fill then drain
    for (int i = 0; i < 4096; i++) write_word(32'h1000 + i, 1'b1);
    end_writes();
    repeat (3) @(negedge clk);
    check("fill_overflow", {63'd0, overflow}, 64'd0);
    check("fill_tvalid",   {63'd0, tvalid},   64'd1);
    tready = 1'b1;
    #2;
    c = 0;
    while (sb.size() > 0 && c < 10000) begin
      @(negedge clk);
      #2;
      c++;
    end
    check("drain_cycles", 64'(c), 64'd4095);
    @(negedge clk);
    #2;
    check("drain_tvalid_end", {63'd0, tvalid},   64'd0);
    check("drain_overflow",   {63'd0, overflow}, 64'd0);

    // Latency into an empty FIFO
    do_reset();
    tready = 1'b1;
    write_word(32'h0000ABCD, 1'b1);
    end_writes();                 // after edge N
    check("lat_n0_tvalid", {63'd0, tvalid}, 64'd0);
    @(negedge clk);               // after N+1
    check("lat_n1_tvalid", {63'd0, tvalid}, 64'd0);
    @(negedge clk);               // after N+2
    check("lat_n2_tvalid", {63'd0, tvalid}, 64'd1);
    check("lat_n2_tdata",  {32'd0, tdata},  64'h0000ABCD);
    @(negedge clk);               // after N+3
    check("lat_n3_tvalid", {63'd0, tvalid}, 64'd0);
    check("lat_n3_tdata_hold", {32'd0, tdata}, 64'h0000ABCD);
    wait_empty("lat", 10);

    // Overflow
    do_reset();
    for (int i = 0; i < 4097; i++) begin
      if (i == 4096) begin
        @(negedge clk);
        check("ovf_before", {63'd0, overflow}, 64'd0);
        din_valid = 1'b1;
        din       = 32'h1100;
      end else begin
        write_word(32'h100 + i, 1'b1);
      end
    end
    end_writes();
    check("ovf_after", {63'd0, overflow}, 64'd1);
    tready = 1'b1;
    wait_empty("ovf", 10000);
    repeat (3) @(negedge clk);
    check("ovf_tvalid_end", {63'd0, tvalid},   64'd0);
    check("ovf_sticky",     {63'd0, overflow}, 64'd1);

    // Concurrent write and read
    do_reset();
    fork
      begin
        for (int i = 0; i < 4096; i++) write_word(32'h1000 - i, 1'b1);
        end_writes();
      end
      begin
        repeat (1000) @(negedge clk);
        tready = 1'b1;
      end
    join
    wait_empty("conc", 10000);
    check("conc_overflow", {63'd0, overflow}, 64'd0);

    // Random backpressure
    do_reset();
    fork
      begin
        for (int i = 0; i < 2048; i++) write_word(32'hB000_0000 + i, 1'b1);
        end_writes();
      end
      begin
        repeat (2100) begin
          @(negedge clk);
          tready = 1'($urandom_range(0, 1));
        end
      end
    join
    @(negedge clk);
    tready = 1'b1;
    wait_empty("bp", 10000);
    check("bp_overflow", {63'd0, overflow}, 64'd0);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
